// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEM_ADR = 4'd3,
        MEM_RD  = 4'd4,
        MEM_WR  = 4'd5,
        LW_WB   = 4'd6,
        R_EXE   = 4'd7,
        R_WB    = 4'd8,
        I_EXE   = 4'd9,
        I_WB    = 4'd10,
        BEQ     = 4'd11,
        JMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [3:0] ALUOP_NONE = 4'd0;
    localparam logic [3:0] ALUOP_ADD  = 4'd2;
    localparam logic [3:0] ALUOP_SUB  = 4'd3;
    localparam logic [3:0] ALUOP_AND  = 4'd4;
    localparam logic [3:0] ALUOP_OR   = 4'd5;
    localparam logic [3:0] ALUOP_SLT  = 4'd12;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_A    = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic logic [3:0] r_aluop(input logic [5:0] f);
        logic [3:0] op;
        op = ALUOP_NONE;
        case (f)
            F_ADD, F_ADDU: op = ALUOP_ADD;
            F_SUB, F_SUBU: op = ALUOP_SUB;
            F_AND:         op = ALUOP_AND;
            F_OR:          op = ALUOP_OR;
            F_SLT:         op = ALUOP_SLT;
            default:       op = ALUOP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic r_legal(input logic [5:0] f);
        return r_aluop(f) != ALUOP_NONE;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU opcode, operand select and immediate-extension decode per state.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] aluop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ext_op
);

    always_comb begin
        aluop     = ALUOP_NONE;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_B;
        ext_op    = EXT_SIGN;
        case (state_t'(state))
            INIT: ext_op = EXT_ZERO;
            FETCH: begin
                alu_src_b = SRCB_FOUR;
                aluop     = ALUOP_ADD;
            end
            // Speculative branch target lands in ALUOut.
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                aluop     = ALUOP_ADD;
            end
            MEM_ADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_ADD;
            end
            R_EXE: begin
                alu_src_a = SRCA_A;
                aluop     = r_aluop(funct);
            end
            I_EXE: begin
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_OR;
                if (opcode == OP_LUI) begin
                    alu_src_a = SRCA_ZERO;
                    ext_op    = EXT_LUI;
                end else begin
                    alu_src_a = SRCA_A;
                    ext_op    = EXT_ZERO;
                end
            end
            BEQ: begin
                alu_src_a = SRCA_A;
                aluop     = ALUOP_SUB;
            end
            MEM_RD, MEM_WR, LW_WB, R_WB, I_WB, JMP: ;
            default: ext_op = EXT_ZERO;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-ALU MIPS datapath,
// with a memory wait counter that aborts stalled accesses.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ext_op,
    output logic [3:0] aluop,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        st;
    state_t        nst;
    logic [CW-1:0] cnt;
    logic          mem_st;
    logic          to_hit;

    assign mem_st = (st == FETCH) || (st == MEM_RD) || (st == MEM_WR);
    // A completion in the expiry cycle takes priority over the abort.
    assign to_hit = mem_st && (cnt == CW'(MEM_TIMEOUT)) && !mem_ready;
    assign state  = st;

    mc_alu_dec u_alu_dec (
        .state     (st),
        .opcode    (opcode),
        .funct     (funct),
        .aluop     (aluop),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op)
    );

    always_comb begin
        nst        = st;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (st)
            INIT: nst = FETCH;
            FETCH: begin
                mem_req = !to_hit;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nst   = DECODE;
                end else if (to_hit) begin
                    bus_err = 1'b1;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    nst = MEM_ADR;
                    OP_BEQ:          nst = BEQ;
                    OP_J:            nst = JMP;
                    OP_ORI, OP_LUI:  nst = I_EXE;
                    OP_RTYPE: begin
                        if (r_legal(funct)) begin
                            nst = R_EXE;
                        end else begin
                            illegal = 1'b1;
                            nst     = FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        nst     = FETCH;
                    end
                endcase
            end
            MEM_ADR: nst = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                mem_req = !to_hit;
                iord    = 1'b1;
                if (mem_ready) begin
                    nst = LW_WB;
                end else if (to_hit) begin
                    bus_err = 1'b1;
                    nst     = FETCH;
                end
            end
            MEM_WR: begin
                mem_req = !to_hit;
                mem_we  = !to_hit;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nst        = FETCH;
                end else if (to_hit) begin
                    bus_err = 1'b1;
                    nst     = FETCH;
                end
            end
            LW_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            R_EXE: nst = R_WB;
            R_WB: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            I_EXE: nst = I_WB;
            I_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            BEQ: begin
                pc_src     = PCSRC_ALUOUT;
                pc_we      = zero;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            JMP: begin
                pc_src     = PCSRC_JUMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            default: nst = FETCH;
        endcase
    end

    // Any cycle without a stalled request (state change, completion,
    // abort) restarts the count, so each access begins from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= INIT;
            cnt <= '0;
        end else begin
            st <= nst;
            if (mem_req && !mem_ready)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected output vectors are
// queued by the stimulus and compared by a negedge monitor.
module tb_mc_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] ext;
        logic [3:0] aluop;
        logic       reg_we;
        logic       reg_dst;
        logic       m2r;
        logic       done;
        logic       ill;
        logic       berr;
        logic [3:0] st;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src, alu_src_a, alu_src_b, ext_op;
    logic [3:0] aluop, state;
    logic       reg_we, reg_dst, mem_to_reg;
    logic       instr_done, illegal, bus_err;

    int checks   = 0;
    int failures = 0;

    ov_t   expq[$];
    string tagq[$];

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .aluop      (aluop),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state)
    );

    always @(negedge clk) begin
        ov_t   e;
        ov_t   act;
        string t;
        if (expq.size() != 0) begin
            e   = expq.pop_front();
            t   = tagq.pop_front();
            act = {mem_req, mem_we, iord, ir_we, pc_we, pc_src,
                   alu_src_a, alu_src_b, ext_op, aluop, reg_we,
                   reg_dst, mem_to_reg, instr_done, illegal,
                   bus_err, state};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s t=%0t got=%07h exp=%07h",
                         t, $time, act, e);
            end
        end
    end

    function automatic ov_t z(input logic [3:0] s);
        ov_t o;
        o     = '0;
        o.st  = s;
        o.ext = (s == 4'd0) ? 2'd0 : 2'd1;
        return o;
    endfunction

    task automatic cyc(input ov_t e, input string tag);
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic rdy, input string tag);
        ov_t e;
        mem_ready = rdy;
        e         = z(4'd1);
        e.mem_req = 1'b1;
        e.b       = 2'd1;
        e.aluop   = 4'd2;
        e.ir_we   = rdy;
        e.pc_we   = rdy;
        cyc(e, tag);
        mem_ready = 1'b0;
    endtask

    task automatic decode(input logic ill, input string tag);
        ov_t e;
        e       = z(4'd2);
        e.b     = 2'd3;
        e.aluop = 4'd2;
        e.ill   = ill;
        cyc(e, tag);
    endtask

    task automatic r_instr(input logic [5:0] f, input logic [3:0] op,
                           input string tag);
        ov_t e;
        opcode = 6'h00;
        funct  = f;
        fetch(1'b1, {tag, "_fetch"});
        decode(1'b0, {tag, "_dec"});
        e       = z(4'd7);
        e.a     = 2'd1;
        e.aluop = op;
        cyc(e, {tag, "_exe"});
        e         = z(4'd8);
        e.reg_we  = 1'b1;
        e.reg_dst = 1'b1;
        e.done    = 1'b1;
        cyc(e, {tag, "_wb"});
    endtask

    task automatic beq_instr(input logic zf, input string tag);
        ov_t e;
        opcode = 6'h04;
        zero   = zf;
        fetch(1'b1, {tag, "_fetch"});
        decode(1'b0, {tag, "_dec"});
        e        = z(4'd11);
        e.a      = 2'd1;
        e.aluop  = 4'd3;
        e.pc_src = 2'd1;
        e.pc_we  = zf;
        e.done   = 1'b1;
        cyc(e, {tag, "_br"});
        zero = 1'b0;
    endtask

    initial begin
        ov_t e;
        rst_n     = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc(z(4'd0), "reset");
        rst_n = 1'b1;
        cyc(z(4'd0), "init");

        r_instr(6'h21, 4'd2, "addu");

        opcode = 6'h23;
        fetch(1'b1, "lw_fetch");
        decode(1'b0, "lw_dec");
        e       = z(4'd3);
        e.a     = 2'd1;
        e.b     = 2'd2;
        e.aluop = 4'd2;
        cyc(e, "lw_adr");
        e         = z(4'd4);
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        repeat (3) cyc(e, "lw_rd_wait");
        mem_ready = 1'b1;
        cyc(e, "lw_rd_done");
        mem_ready = 1'b0;
        e        = z(4'd6);
        e.reg_we = 1'b1;
        e.m2r    = 1'b1;
        e.done   = 1'b1;
        cyc(e, "lw_wb");

        beq_instr(1'b1, "beq_taken");
        beq_instr(1'b0, "beq_not");

        opcode = 6'h0F;
        fetch(1'b1, "lui_fetch");
        decode(1'b0, "lui_dec");
        e       = z(4'd9);
        e.a     = 2'd2;
        e.b     = 2'd2;
        e.ext   = 2'd2;
        e.aluop = 4'd5;
        cyc(e, "lui_exe");
        e        = z(4'd10);
        e.reg_we = 1'b1;
        e.done   = 1'b1;
        cyc(e, "lui_wb");

        r_instr(6'h2A, 4'd12, "slt");

        opcode = 6'h3F;
        fetch(1'b1, "ill_fetch");
        decode(1'b1, "ill_dec");

        opcode = 6'h02;
        fetch(1'b1, "j_fetch");
        decode(1'b0, "j_dec");
        e        = z(4'd12);
        e.pc_we  = 1'b1;
        e.pc_src = 2'd2;
        e.done   = 1'b1;
        cyc(e, "j_jmp");

        opcode = 6'h2B;
        repeat (4) fetch(1'b0, "to_wait");
        e       = z(4'd1);
        e.b     = 2'd1;
        e.aluop = 4'd2;
        e.berr  = 1'b1;
        cyc(e, "to_abort");
        fetch(1'b0, "to_refetch");
        repeat (3) fetch(1'b0, "to_wait2");
        fetch(1'b1, "to_late_ready");
        decode(1'b0, "sw_dec");
        e       = z(4'd3);
        e.a     = 2'd1;
        e.b     = 2'd2;
        e.aluop = 4'd2;
        cyc(e, "sw_adr");
        e         = z(4'd5);
        e.mem_req = 1'b1;
        e.mem_we  = 1'b1;
        e.iord    = 1'b1;
        cyc(e, "sw_wr");
        expq.push_back(z(4'd0));
        tagq.push_back("sw_async_rst");
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc(z(4'd0), "rst_hold");
        rst_n = 1'b1;
        cyc(z(4'd0), "init2");
        fetch(1'b0, "fetch2");

        repeat (3) @(posedge clk);
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the single-ALU MIPS datapath. One instruction at a time goes through fetch, decode, execute, memory and writeback.
- Every state drives the ALU operand selects and the 4-bit ALU opcode: 2 add, 3 sub, 4 and, 5 or, 12 slt.
- Drives all datapath write enables and the memory request handshake.
- Sits between the datapath (IR, PC, A/B/ALUOut registers, regfile) and the unified instruction/data memory port.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles the FSM waits for mem_ready before aborting the access; counter width is clog2(MEM_TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (combinational, same cycle)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_we  out  1  load IR
- pc_we  out  1  load PC
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target {PC[31:28], IR[25:0], 2'b00}
- alu_src_a  out  2  0 = PC, 1 = A, 2 = constant 0
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = ext imm, 3 = ext imm<<2
- ext_op  out  2  0 = zero-extend, 1 = sign-extend, 2 = imm<<16
- aluop  out  4  ALU opcode
- reg_we  out  1  regfile write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on undecodable opcode/funct
- bus_err  out  1  one-cycle pulse on memory timeout
- state  out  4  current state (debug)

Behaviour:
- Moore outputs decoded from state. Exceptions: pc_we in BEQ depends on zero; ir_we/pc_we in FETCH depend on mem_ready.
- Any output not listed for a state is 0. Default ext_op = 1 (sign-extend).
- Reset (async, rst_n=0): state=INIT, wait counter=0, all outputs 0.
- INIT: all controls 0; next state FETCH. The first fetch request is issued in the second cycle after reset release.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, aluop=2.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0; next DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, aluop=2 (branch target into ALUOut). Next state by opcode:
  - 0x23 lw, 0x2B sw -> MEM_ADR
  - 0x00 -> R_EXE, only if funct is one of 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x2A
  - 0x04 -> BEQ
  - 0x02 -> JMP
  - 0x0D ori, 0x0F lui -> I_EXE
  - anything else: illegal=1, next FETCH
- MEM_ADR: alu_src_a=1, alu_src_b=2, ext_op=1, aluop=2; next MEM_RD if lw, MEM_WR if sw.
- MEM_RD: mem_req=1, iord=1; on mem_ready next LW_WB.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on mem_ready instr_done=1, next FETCH.
- LW_WB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1; next FETCH.
- R_EXE: alu_src_a=1, alu_src_b=0. aluop by funct:
  - 0x20/0x21 -> 2
  - 0x22/0x23 -> 3
  - 0x24 -> 4
  - 0x25 -> 5
  - 0x2A -> 12
  - next R_WB
- R_WB: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
- I_EXE:
  - ori: alu_src_a=1, alu_src_b=2, ext_op=0, aluop=5
  - lui: alu_src_a=2, alu_src_b=2, ext_op=2, aluop=5
  - next I_WB
- I_WB: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, aluop=3, pc_src=1, pc_we=zero, instr_done=1; next FETCH.
- JMP: pc_we=1, pc_src=2, instr_done=1; next FETCH.
- Instruction latency, zero-wait memory: lw 5, sw 4, R/ori/lui 4, beq 3, j 3 cycles.
- Wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - At MEM_TIMEOUT: bus_err=1, drop mem_req, write enables stay 0, next FETCH. PC is unchanged, so the fetch is retried.
- mem_ready while mem_req=0 is ignored.
- mem_ready in the same cycle as timeout: completion wins, no bus_err.
- Reset asserted mid-instruction: immediate INIT. No partial write enable survives, since outputs are decoded from state.
- Illegal state encodings recover to FETCH.

Decomposition:
- Package mc_pkg:
  - state enum: INIT, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WR, LW_WB, R_EXE, R_WB, I_EXE, I_WB, BEQ, JMP
  - opcode and funct constants
  - ALUOP_ADD=2, SUB=3, AND=4, OR=5, SLT=12
  - src-select and ext_op encodings
- Sub-module mc_alu_dec: combinational (state, opcode, funct) -> aluop, alu_src_a, alu_src_b, ext_op.
- FSM and timeout counter stay in mc_ctrl.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; INIT for 1 cycle; FETCH with mem_req=1 on the 2nd cycle after release.
- Zero-wait addu (opcode 0, funct 0x21) -> states FETCH, DECODE, R_EXE (aluop=2), R_WB (reg_we=1, reg_dst=1); instr_done on cycle 4.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_req, iord=1 held 4 cycles; LW_WB mem_to_reg=1, reg_we=1; no bus_err.
- beq with zero=1 -> pc_we=1, pc_src=1 in the BEQ state. Repeat with zero=0 -> pc_we=0; both return to FETCH.
- lui then slt (funct 0x2A) -> lui I_EXE: alu_src_a=2, ext_op=2, aluop=5. slt R_EXE: aluop=12. Then opcode 0x3F -> illegal pulse in DECODE, next FETCH.
- mem_ready never asserted in FETCH with MEM_TIMEOUT=4 -> bus_err pulse after 4 waiting cycles, FETCH re-entered, pc_we never asserted. Also rst_n dropped mid MEM_WR -> mem_we deasserts immediately (async).
